// File: rtl/ws_result_drain_pkg.sv
// Shared definitions for the weight-stationary result drain: FSM encoding and row-counter width.
package ws_result_drain_pkg;

    localparam int unsigned ROW_CNT_W = 16;

    typedef logic [ROW_CNT_W-1:0] row_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } drain_state_e;

endpackage

// File: rtl/ws_result_drain_sync_fifo.sv
// Shift-register FIFO; the head entry is a register so rd_data/rd_valid come straight from flops.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full_c
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    wr_pos;
    logic             vld_q;
    logic             rd_ok;
    logic             wr_ok;

    assign full_c = (cnt_q == CW'(DEPTH));
    assign rd_ok  = rd_en && (cnt_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign wr_ok  = wr_en && (!full_c || rd_ok);
    assign wr_pos = cnt_q - CW'(rd_ok);

    // Next contents: shift down on pop, then write behind the surviving entries.
    always_comb begin
        mem_d = mem_q;
        if (rd_ok) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[DEPTH-1] = '0;
        end
        if (wr_ok) begin
            mem_d[AW'(wr_pos)] = wr_data;
        end
        cnt_d = cnt_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            vld_q <= (cnt_d != '0);
        end
    end

    assign rd_data  = mem_q[0];
    assign rd_valid = vld_q;
    assign count    = cnt_q;

endmodule

// File: rtl/ws_result_drain.sv
// Deskews the diagonal result wavefront of a systolic array and streams aligned rows out of a FIFO.
module ws_result_drain
    import ws_result_drain_pkg::*;
#(
    parameter int unsigned COLS      = 4,
    parameter int unsigned WIDTH_MAC = 48,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_clear,
    input  logic                      start,
    input  logic [15:0]               num_rows,
    input  logic [COLS-1:0]           col_valid,
    input  logic [COLS*WIDTH_MAC-1:0] col_mac,
    output logic                      drain_stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*WIDTH_MAC-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err_align,
    output logic                      err_ovf
);

    localparam int unsigned DW        = COLS * WIDTH_MAC;
    localparam int unsigned CW        = $clog2(DEPTH + 1);
    localparam int unsigned STALL_LVL = DEPTH - COLS;

    drain_state_e state_q, state_d;
    row_cnt_t     rows_q, push_cnt_q, pop_cnt_q, pop_cnt_d;

    logic [COLS-1:0]                 dsk_v;
    logic [COLS-1:0][WIDTH_MAC-1:0]  dsk_d;
    logic                            all_v, any_v;

    logic [CW-1:0] fifo_cnt, fifo_cnt_d;
    logic          fifo_full_c;
    logic          fifo_valid;
    logic [DW-1:0] fifo_data;

    logic push_req_c, push_ok_c, pop_c, job_start_c, align_err_c, ovf_c, last_d_c;

    // Column c arrives c cycles after column 0; delay it COLS-1-c cycles to line the row up.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int unsigned D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign dsk_v[c] = col_valid[c];
            assign dsk_d[c] = col_mac[c*WIDTH_MAC +: WIDTH_MAC];
        end else begin : g_dly
            logic [D-1:0]         v_sr;
            logic [WIDTH_MAC-1:0] d_sr [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_sr <= '0;
                    for (int unsigned k = 0; k < D; k++) d_sr[k] <= '0;
                end else if (reg_clear) begin
                    v_sr <= '0;
                    for (int unsigned k = 0; k < D; k++) d_sr[k] <= '0;
                end else begin
                    v_sr[0] <= col_valid[c];
                    d_sr[0] <= col_mac[c*WIDTH_MAC +: WIDTH_MAC];
                    for (int unsigned k = 1; k < D; k++) begin
                        v_sr[k] <= v_sr[k-1];
                        d_sr[k] <= d_sr[k-1];
                    end
                end
            end

            assign dsk_v[c] = v_sr[D-1];
            assign dsk_d[c] = d_sr[D-1];
        end
    end

    assign all_v = &dsk_v;
    assign any_v = |dsk_v;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (reg_clear),
        .wr_en    (push_req_c),
        .wr_data  (dsk_d),
        .rd_en    (pop_c),
        .rd_data  (fifo_data),
        .rd_valid (fifo_valid),
        .count    (fifo_cnt),
        .full_c   (fifo_full_c)
    );

    assign out_valid   = fifo_valid;
    assign out_data    = fifo_data;
    assign pop_c       = fifo_valid && out_ready;
    assign drain_stall = (fifo_cnt >= CW'(STALL_LVL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (reg_clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the per-cycle push/error decisions.
    always_comb begin
        state_d     = state_q;
        push_req_c  = 1'b0;
        push_ok_c   = 1'b0;
        job_start_c = 1'b0;
        align_err_c = 1'b0;
        ovf_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    job_start_c = 1'b1;
                    state_d     = (num_rows != '0) ? ST_COLLECT : ST_DONE;
                end
            end
            ST_COLLECT: begin
                push_req_c  = all_v;
                push_ok_c   = all_v && (!fifo_full_c || pop_c);
                ovf_c       = all_v && fifo_full_c && !pop_c;
                align_err_c = any_v && !all_v;
                if (push_ok_c && (push_cnt_q + row_cnt_t'(1) == rows_q)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (pop_c && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The head row is the last one when every earlier row of the job has already transferred.
    always_comb begin
        fifo_cnt_d = fifo_cnt + CW'(push_ok_c) - CW'(pop_c);
        pop_cnt_d  = job_start_c ? '0 : pop_cnt_q + row_cnt_t'(pop_c);
        last_d_c   = (state_d == ST_FLUSH) && (fifo_cnt_d != '0) &&
                     (pop_cnt_d + row_cnt_t'(1) == rows_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q     <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            err_align  <= 1'b0;
            err_ovf    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_last   <= 1'b0;
        end else if (reg_clear) begin
            rows_q     <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            err_align  <= 1'b0;
            err_ovf    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            if (job_start_c) begin
                rows_q     <= num_rows;
                push_cnt_q <= '0;
            end else if (push_ok_c) begin
                push_cnt_q <= push_cnt_q + row_cnt_t'(1);
            end
            pop_cnt_q <= pop_cnt_d;
            err_align <= err_align | align_err_c;
            err_ovf   <= err_ovf | ovf_c;
            busy      <= (state_d == ST_COLLECT) || (state_d == ST_FLUSH);
            done      <= (state_d == ST_DONE);
            out_last  <= last_d_c;
        end
    end

endmodule
